// File: rtl/cla_pg_pipe.sv
// cla_pg_pipe: two-stage valid/ready pipeline producing bit and nibble-group propagate/generate for a CLA.
// Optional macro CLA_PG_SUB_EN adds a sub input that inverts b and forces carry-in for a - b.
module cla_pg_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_in,
`ifdef CLA_PG_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH/4-1:0] gp,
  output logic [WIDTH/4-1:0] gg,
  output logic             cin_out
);
  localparam int NGRP = WIDTH / 4;
  logic [WIDTH-1:0] b_eff, s1_p, s1_g;
  logic             c_eff, s1_c, s1_v, s2_v, in_xfer, s2_adv;
  logic [NGRP-1:0]  gp_c, gg_c;
`ifdef CLA_PG_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin_in;
`else
  assign b_eff = b;
  assign c_eff = cin_in;
`endif
  assign s2_adv    = s1_v & (!s2_v | out_ready);
  assign in_ready  = !s1_v | s2_adv;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = s2_v;
  for (genvar k = 0; k < NGRP; k++) begin : grp
    logic [3:0] gp4, gg4;
    assign gp4 = s1_p[4*k +: 4];
    assign gg4 = s1_g[4*k +: 4];
    assign gp_c[k] = &gp4;
    assign gg_c[k] = gg4[3] | (gp4[3] & gg4[2]) | (gp4[3] & gp4[2] & gg4[1]) |
                     (gp4[3] & gp4[2] & gp4[1] & gg4[0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_p    <= '0;
      s1_g    <= '0;
      s1_c    <= 1'b0;
      s2_v    <= 1'b0;
      p       <= '0;
      g       <= '0;
      gp      <= '0;
      gg      <= '0;
      cin_out <= 1'b0;
    end else begin
      s1_v <= in_xfer ? 1'b1 : (s2_adv ? 1'b0 : s1_v);
      s2_v <= s2_adv ? 1'b1 : (out_ready ? 1'b0 : s2_v);
      if (in_xfer) begin
        s1_p <= a ^ b_eff;
        s1_g <= a & b_eff;
        s1_c <= c_eff;
      end
      if (s2_adv) begin
        p       <= s1_p;
        g       <= s1_g;
        gp      <= gp_c;
        gg      <= gg_c;
        cin_out <= s1_c;
      end
    end
  end
endmodule

// File: tb/tb_cla_pg_pipe.sv
// tb_cla_pg_pipe: scoreboard bench for cla_pg_pipe covering latency, throughput, stall, reset and random traffic.
module tb_cla_pg_pipe;
  localparam int W = 8;
  localparam int NG = W / 4;
  typedef struct packed {
    logic [W-1:0]  p;
    logic [W-1:0]  g;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic          c;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, cin_in = 0, sub = 0;
  logic in_ready, out_valid, cin_out;
  logic [W-1:0] a = 0, b = 0, p, g;
  logic [NG-1:0] gp, gg;
  int checks = 0, errors = 0, n_out = 0;
  exp_t sb[$];
  cla_pg_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin_in(cin_in),
`ifdef CLA_PG_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .g(g), .gp(gp), .gg(gg), .cin_out(cin_out)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms);
    exp_t e;
    logic [W-1:0] bb;
    logic t;
`ifdef CLA_PG_SUB_EN
    bb = ms ? ~mb : mb;
    e.c = ms | mc;
`else
    bb = mb;
    e.c = mc;
    t = ms;
`endif
    e.p = ma ^ bb;
    e.g = ma & bb;
    for (int k = 0; k < NG; k++) begin
      e.gp[k] = &e.p[4*k +: 4];
      t = 1'b0;
      for (int j = 0; j < 4; j++) t = e.g[4*k+j] | (e.p[4*k+j] & t);
      e.gg[k] = t;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got=%h", {p, g, gp, gg, cin_out});
        end else begin
          e = sb.pop_front();
          if ({p, g, gp, gg, cin_out} !== e) begin
            errors++;
            $display("FAIL sb_data got=%h exp=%h", {p, g, gp, gg, cin_out}, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, cin_in, sub));
    end
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_out(input int target, input string name);
    for (int i = 0; i < 50 && n_out < target; i++) cyc();
    checks++;
    if (n_out != target) begin
      errors++;
      $display("FAIL %s delivered=%0d exp=%0d", name, n_out, target);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {p, g, gp, gg, cin_out} !== '0) begin
      errors++;
      $display("FAIL reset_state ov=%b ir=%b data=%h exp ov=0 ir=1 data=0",
               out_valid, in_ready, {p, g, gp, gg, cin_out});
    end
  endtask
  task automatic send_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                          input logic vs, input exp_t want, input string name);
    out_ready = 1;
    in_valid = 1;
    a = va;
    b = vb;
    cin_in = vc;
    sub = vs;
    cyc();
    in_valid = 0;
    sub = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency1 ov=%b exp=0", name, out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || {p, g, gp, gg, cin_out} !== want) begin
      errors++;
      $display("FAIL %s ov=%b got=%h exp=%h", name, out_valid, {p, g, gp, gg, cin_out}, want);
    end
    cyc();
  endtask
  task automatic test_vectors;
    send_vec(8'hFF, 8'h01, 1'b0, 1'b0, {8'hFE, 8'h01, 2'b10, 2'b01, 1'b0}, "vec_ff_01");
    send_vec(8'h5A, 8'hA5, 1'b1, 1'b0, {8'hFF, 8'h00, 2'b11, 2'b00, 1'b1}, "vec_5a_a5");
    send_vec(8'h00, 8'h00, 1'b0, 1'b0, {8'h00, 8'h00, 2'b00, 2'b00, 1'b0}, "vec_zero");
  endtask
  task automatic test_back_to_back;
    int start = n_out;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      a = W'($urandom);
      b = W'($urandom);
      cin_in = 1'($urandom);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready i=%0d got=%b exp=1", i, in_ready);
      end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_out_valid i=%0d got=%b exp=1", i, out_valid);
        end
      end
      cyc();
    end
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== (i < 2)) begin
        errors++;
        $display("FAIL b2b_tail i=%0d got=%b exp=%b", i, out_valid, i < 2);
      end
      cyc();
    end
    wait_out(start + 4, "b2b_count");
  endtask
  task automatic test_stall;
    int start = n_out;
    logic [2*W+2*NG:0] snap;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      a = W'($urandom);
      b = W'($urandom);
      cin_in = 1'($urandom);
      #1;
      checks++;
      if (in_ready !== (i < 2)) begin
        errors++;
        $display("FAIL stall_in_ready i=%0d got=%b exp=%b", i, in_ready, i < 2);
      end
      if (i < 2) cyc();
    end
    snap = {p, g, gp, gg, cin_out};
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {p, g, gp, gg, cin_out} !== snap) begin
        errors++;
        $display("FAIL stall_hold i=%0d ov=%b ir=%b got=%h exp=%h", i, out_valid, in_ready,
                 {p, g, gp, gg, cin_out}, snap);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_in_ready got=%b exp=1", in_ready);
    end
    cyc();
    in_valid = 0;
    wait_out(start + 3, "stall_count");
    cyc();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain sb=%0d ov=%b exp sb=0 ov=0", sb.size(), out_valid);
    end
  endtask
  task automatic test_reset_mid;
    int start;
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1;
      a = W'($urandom) | 8'h11;
      b = W'($urandom) | 8'h22;
      cin_in = 1;
      cyc();
    end
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_full ov=%b ir=%b exp ov=1 ir=0", out_valid, in_ready);
    end
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {p, g, gp, gg, cin_out} !== '0) begin
      errors++;
      $display("FAIL rstmid_state ov=%b ir=%b data=%h exp ov=0 ir=1 data=0",
               out_valid, in_ready, {p, g, gp, gg, cin_out});
    end
    start = n_out;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale i=%0d ov=%b exp=0", i, out_valid);
      end
    end
    checks++;
    if (n_out != start) begin
      errors++;
      $display("FAIL rstmid_no_output delivered=%0d exp=%0d", n_out - start, 0);
    end
  endtask
`ifdef CLA_PG_SUB_EN
  task automatic test_sub;
    send_vec(8'h10, 8'h01, 1'b0, 1'b1, {8'hEE, 8'h10, 2'b00, 2'b10, 1'b1}, "sub_10_01");
  endtask
`endif
  task automatic test_random;
    logic acc;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1;
        a = W'($urandom);
        b = W'($urandom);
        cin_in = 1'($urandom);
`ifdef CLA_PG_SUB_EN
        sub = 1'($urandom);
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      cyc();
      if (acc) in_valid = 0;
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) cyc();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain sb=%0d ov=%b exp sb=0 ov=0", sb.size(), out_valid);
    end
  endtask
  initial begin
    cyc();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef CLA_PG_SUB_EN
    test_sub();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
